mem_arbiter: RTL

Memory-side responder for the pipeline's request/acknowledge read ports. Serves the instruction-fetch read port and the data (load/store) port, one access at a time, against a single-port synchronous memory with fixed read latency. Returns `ack` plus data to the winning requester. Sits between the IF/MEM stages and the memory macro.

---
 rtl/mem_arbiter_pkg.sv | 29 ++
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/mem_arb_select.sv | 28 ++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 4;
  localparam int CNT_W           = 3;

  // One access as latched at grant time; drives the memory pins directly.
  typedef struct packed {
    gnt_e        port;
    logic        we;
    logic [3:0]  be;
    logic [29:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/ack ports for fetch and data plus the memory macro pins.
interface mem_arbiter_if;

  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_data;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    output i_ack, i_data, d_ack, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_rdata,
    input  i_ack, i_data, d_ack, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner pick; data port wins ties unless MEM_ARBITER_RR_EN,
// in which case the port not granted last wins.
module mem_arb_select
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
  input  gnt_e i_last_grant,
`endif
  input  logic i_ireq,
  input  logic i_dreq,
  output logic o_vld,
  output gnt_e o_gnt
);

  always_comb begin
    o_vld = i_ireq | i_dreq;
    o_gnt = GNT_D;
    if (i_ireq && !i_dreq) begin
      o_gnt = GNT_I;
    end
`ifdef MEM_ARBITER_RR_EN
    else if (i_ireq && i_dreq) begin
      o_gnt = (i_last_grant == GNT_D) ? GNT_I : GNT_D;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serves fetch and data ports one access at a time; read ack at mem_en+MEM_LATENCY+1,
// store ack at mem_en+1. MEM_ARBITER_RR_EN selects round-robin ties.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LATENCY);

  state_e           r_state, w_next;
  req_t             r_req, w_new;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic             w_sel_vld, w_start, w_capture;
  gnt_e             w_gnt;
  logic             r_i_ack, r_d_ack, r_mem_en, r_mem_we;
  logic [31:0]      r_i_data, r_d_rdata;
  logic             w_unused;

  // Memory is word addressed; the byte offset is deliberately dropped.
  assign w_unused = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

  assign w_start = (r_state == IDLE) && w_sel_vld;

`ifdef MEM_ARBITER_RR_EN
  gnt_e r_last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= GNT_I;
    end else if (w_start) begin
      r_last_grant <= w_gnt;
    end
  end
`endif

  mem_arb_select u_select (
`ifdef MEM_ARBITER_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .i_ireq       (bus.i_req),
    .i_dreq       (bus.d_req),
    .o_vld        (w_sel_vld),
    .o_gnt        (w_gnt)
  );

  always_comb begin
    w_new       = '0;
    w_new.port  = w_gnt;
    w_new.we    = (w_gnt == GNT_D) && bus.d_we;
    w_new.be    = (w_gnt == GNT_D) ? bus.d_be : 4'hF;
    w_new.addr  = (w_gnt == GNT_D) ? bus.d_addr[31:2] : bus.i_addr[31:2];
    w_new.wdata = bus.d_wdata;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_vld) w_next = ISSUE;
      end
      ISSUE: begin
        if (r_req.we) begin
          w_next = ACK;
        end else begin
          w_next     = WAIT;
          w_cnt_next = LAT;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_capture = 1'b1;
          w_next    = ACK;
        end
      end
      ACK: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_cnt     <= '0;
      r_mem_en  <= 1'b0;
      r_mem_we  <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_data  <= '0;
      r_d_rdata <= '0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_mem_en <= w_start;
      r_mem_we <= w_start && w_new.we;
      r_i_ack  <= (w_next == ACK) && (r_req.port == GNT_I);
      r_d_ack  <= (w_next == ACK) && (r_req.port == GNT_D);
      if (w_start) begin
        r_req <= w_new;
      end
      if (w_capture && (r_req.port == GNT_I)) begin
        r_i_data <= bus.mem_rdata;
      end
      if (w_capture && (r_req.port == GNT_D)) begin
        r_d_rdata <= bus.mem_rdata;
      end
    end
  end

  assign bus.i_ack     = r_i_ack;
  assign bus.i_data    = r_i_data;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_req.be;
  assign bus.mem_addr  = r_req.addr;
  assign bus.mem_wdata = r_req.wdata;

endmodule
